aes_inv_cipher_iter: RTL and testbench

- Iterative AES-128 decryption core: the inverse direction of the existing encryption datapath.
- Performs one inverse round per clock, using InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
- Round keys come from the existing expanded-key store through an index/data read port.
- Valid/ready handshakes on input and output; sits beside the encrypt core in the AES top level.

---
 rtl/aes_inv_cipher_iter.sv | 145 ++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock.
// Round keys are fetched from an external expanded-key store via rk_idx/rk.
// The state register doubles as the plaintext output register.
module aes_inv_cipher_iter #(
   parameter int NK = 4,
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic         busy
);

   // Only AES-128 is implemented; refuse to build anything else.
   generate
      if (NK != 4 || NR != NK + 6) begin : g_bad_param
         $error("aes_inv_cipher_iter: only NK=4, NR=10 is supported");
      end
   endgenerate

   // FIPS-197 inverse S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {IDLE, ROUND, DONE} st_t;

   st_t          st;
   logic [3:0]   round;
   logic [127:0] state;
   logic [127:0] nxt;

   // GF(2^8) multiply by x, modulus 0x11B
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul_9(input logic [7:0] a);
      return xt(xt(xt(a))) ^ a;
   endfunction

   function automatic logic [7:0] mul_b(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(a) ^ a;
   endfunction

   function automatic logic [7:0] mul_d(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
   endfunction

   function automatic logic [7:0] mul_e(input logic [7:0] a);
      return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
   endfunction

   // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last
   function automatic logic [127:0] inv_round(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input logic         last);
      logic [127:0] t;
      logic [127:0] m;
      logic [7:0]   a0, a1, a2, a3;
      t = '0;
      m = '0;
      // row j of column c comes from column (c - j) mod 4
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) begin
            t[127-8*(4*c+j) -: 8] = INV_SBOX[s[127-8*(4*((c+4-j)%4)+j) -: 8]];
         end
      end
      t = t ^ k;
      for (int c = 0; c < 4; c++) begin
         a0 = t[127-32*c -: 8];
         a1 = t[119-32*c -: 8];
         a2 = t[111-32*c -: 8];
         a3 = t[103-32*c -: 8];
         m[127-32*c -: 32] = {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
                              mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
                              mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
                              mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
      end
      return last ? t : m;
   endfunction

   // next state for the current round; last round skips InvMixColumns
   always_comb begin
      nxt = inv_round(state, rk, round == 4'd0);
   end

   // control/status decoded from registered FSM state only
   assign in_ready  = (st == IDLE);
   assign out_valid = (st == DONE);
   assign busy      = (st != IDLE);
   assign rk_idx    = (st == ROUND) ? round : 4'(NR);
   assign plaintext = state;

   // FSM: accept (initial AddRoundKey), NR inverse rounds, hold until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st    <= IDLE;
         round <= 4'd0;
         state <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (in_valid) begin
                  state <= ciphertext ^ rk;
                  round <= 4'(NR - 1);
                  st    <= ROUND;
               end
            end
            ROUND: begin
               state <= nxt;
               if (round == 4'd0) st <= DONE;
               else               round <= round - 4'd1;
            end
            DONE: begin
               if (out_ready) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 vectors, backpressure,
// back-to-back streaming, asynchronous reset and an encrypt/decrypt round trip.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ciphertext;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plaintext;
   logic         busy;

   logic [127:0] ks [11];
   logic [7:0]   sb [256];
   int           total = 0;
   int           bad   = 0;

   aes_inv_cipher_iter #(.NK(4), .NR(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ciphertext(ciphertext), .rk_idx(rk_idx), .rk(rk),
      .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // key store read port: combinational lookup
   always_comb rk = (rk_idx <= 4'd10) ? ks[rk_idx] : '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // forward S-box from its definition: GF inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sb[8'(x)] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                     ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // reference forward cipher using the current key store
   function automatic logic [127:0] enc(input logic [127:0] pt);
      logic [127:0] s, a, b;
      logic [7:0]   c0, c1, c2, c3;
      s = pt ^ ks[0];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) a[127-8*i -: 8] = sb[s[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
               b[127-8*(4*c+j) -: 8] = a[127-8*(4*((c+j)%4)+j) -: 8];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               c0 = b[127-32*c -: 8]; c1 = b[119-32*c -: 8];
               c2 = b[111-32*c -: 8]; c3 = b[103-32*c -: 8];
               b[127-32*c -: 32] = {gmul(8'h02,c0) ^ gmul(8'h03,c1) ^ c2 ^ c3,
                                    c0 ^ gmul(8'h02,c1) ^ gmul(8'h03,c2) ^ c3,
                                    c0 ^ c1 ^ gmul(8'h02,c2) ^ gmul(8'h03,c3),
                                    gmul(8'h03,c0) ^ c1 ^ c2 ^ gmul(8'h02,c3)};
            end
         end
         s = b ^ ks[r];
      end
      return s;
   endfunction

   // one block from IDLE with out_ready high; full=1 also checks each round cycle
   task automatic run_block(input string tag, input logic [127:0] ct,
                            input logic [127:0] exp, input bit full);
      in_valid   = 1'b1;
      ciphertext = ct;
      if (full) begin
         chk({tag, " idle rk_idx"}, 128'(rk_idx), 128'd10);
         chk({tag, " idle in_ready"}, 128'(in_ready), 128'd1);
      end
      @(posedge clk); #1;
      in_valid   = 1'b0;
      ciphertext = '0;
      for (int i = 9; i >= 0; i--) begin
         if (full) begin
            chk({tag, " round rk_idx"}, 128'(rk_idx), 128'(i));
            chk({tag, " round out_valid"}, 128'(out_valid), 128'd0);
            chk({tag, " round busy"}, 128'(busy), 128'd1);
         end
         @(posedge clk); #1;
      end
      chk({tag, " out_valid"}, 128'(out_valid), 128'd1);
      chk({tag, " plaintext"}, plaintext, exp);
      @(posedge clk); #1;
      if (full) begin
         chk({tag, " post out_valid"}, 128'(out_valid), 128'd0);
         chk({tag, " post in_ready"}, 128'(in_ready), 128'd1);
      end
   endtask

   logic [127:0] key, pt;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ciphertext = '0;
      build_sbox();
      expand(K1);
      #1;
      chk("reset in_ready", 128'(in_ready), 128'd1);
      chk("reset out_valid", 128'(out_valid), 128'd0);
      chk("reset busy", 128'(busy), 128'd0);
      chk("reset rk_idx", 128'(rk_idx), 128'd10);
      chk("reset plaintext", plaintext, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // FIPS-197 C.1 and Appendix B
      run_block("c1", C1, P1, 1'b1);
      expand(KB);
      run_block("appb", CB, PB, 1'b1);

      // backpressure with in_valid held high
      expand(K1);
      out_ready = 1'b0;
      in_valid = 1'b1; ciphertext = C1;
      @(posedge clk); #1;
      ciphertext = CB;
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         chk("bp out_valid", 128'(out_valid), 128'd1);
         chk("bp plaintext", plaintext, P1);
         chk("bp in_ready", 128'(in_ready), 128'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp release out_valid", 128'(out_valid), 128'd0);
      chk("bp release in_ready", 128'(in_ready), 128'd1);
      chk("bp release plaintext", plaintext, P1);

      // back-to-back: second acceptance exactly 12 edges after the first
      in_valid = 1'b1; ciphertext = C1;
      @(posedge clk); #1;
      ciphertext = CB;
      chk("b2b first busy", 128'(busy), 128'd1);
      repeat (10) @(posedge clk);
      #1;
      chk("b2b first out_valid", 128'(out_valid), 128'd1);
      chk("b2b first plaintext", plaintext, P1);
      chk("b2b done in_ready", 128'(in_ready), 128'd0);
      expand(KB);
      @(posedge clk); #1;
      chk("b2b gap in_ready", 128'(in_ready), 128'd1);
      chk("b2b gap out_valid", 128'(out_valid), 128'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b second rk_idx", 128'(rk_idx), 128'd9);
      repeat (10) @(posedge clk);
      #1;
      chk("b2b second out_valid", 128'(out_valid), 128'd1);
      chk("b2b second plaintext", plaintext, PB);
      @(posedge clk); #1;

      // asynchronous reset in the middle of a block
      expand(K1);
      in_valid = 1'b1; ciphertext = C1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre-rst rk_idx", 128'(rk_idx), 128'd5);
      rst = 1'b1;
      #1;
      chk("rst out_valid", 128'(out_valid), 128'd0);
      chk("rst plaintext", plaintext, '0);
      chk("rst in_ready", 128'(in_ready), 128'd1);
      chk("rst rk_idx", 128'(rk_idx), 128'd10);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         chk("post-rst out_valid", 128'(out_valid), 128'd0);
         @(posedge clk); #1;
      end
      run_block("c1 after rst", C1, P1, 1'b1);

      // round trip against the reference encryptor
      for (int n = 0; n < 100; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand(key);
         run_block("roundtrip", enc(pt), pt, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
